spectral_peak_finder: RTL and testbench

//  Streaming successor to the 16-bin parallel frequency analyser. Accepts one complex FFT bin per

---
 rtl/spectral_peak_finder_if.sv | 25 ++
 rtl/spectral_peak_finder.sv | 95 +++++++++
 tb/tb_spectral_peak_finder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/spectral_peak_finder_if.sv
// Bin stream in, frame peak result out, for the spectral peak finder.
interface spectral_peak_finder_if #(
  parameter int DW = 16,
  parameter int IW = 4
);
  logic              in_valid;
  logic              in_sof;
  logic [2*DW-1:0]   in_data;
  logic [2*DW-1:0]   min_mag;
  logic              out_valid;
  logic [IW-1:0]     out_idx;
  logic [2*DW-1:0]   out_mag;
  logic              out_nopeak;
  logic              frame_err;

  modport master (
    output in_valid, in_sof, in_data, min_mag,
    input  out_valid, out_idx, out_mag, out_nopeak, frame_err
  );

  modport slave (
    input  in_valid, in_sof, in_data, min_mag,
    output out_valid, out_idx, out_mag, out_nopeak, frame_err
  );
endinterface

// File: rtl/spectral_peak_finder.sv
// Streaming |X|^2 peak tracker: one complex bin per cycle, reports the peak
// bin, its magnitude and a below-threshold flag once per NBINS-bin frame.
module spectral_peak_finder #(
  parameter int DW    = 16,
  parameter int NBINS = 16,
  parameter int IW    = $clog2(NBINS)
) (
  input  logic                  clk,
  input  logic                  rst,
  spectral_peak_finder_if.slave bus
);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBINS - 1);

  logic signed [2*DW-1:0] re_ext, im_ext;
  logic [IW-1:0]          bin_cnt, cur_idx;
  logic                   mid_sof, cur_last;

  logic                   s1_valid, s1_last;
  logic [IW-1:0]          s1_idx;
  logic [2*DW-1:0]        s1_re_sq, s1_im_sq, s1_min, sum;

  logic [2*DW-1:0]        max_mag, s2_min;
  logic [IW-1:0]          max_idx;
  logic                   s2_done;

  logic                   out_valid_r, out_nopeak_r, frame_err_r;
  logic [IW-1:0]          out_idx_r;
  logic [2*DW-1:0]        out_mag_r;

  assign re_ext = {{DW{bus.in_data[2*DW-1]}}, bus.in_data[2*DW-1:DW]};
  assign im_ext = {{DW{bus.in_data[DW-1]}}, bus.in_data[DW-1:0]};

  // A mid-frame sof restarts numbering at 0 on the very bin that carries it.
  always_comb begin
    mid_sof  = bus.in_valid && bus.in_sof && (bin_cnt != '0);
    cur_idx  = mid_sof ? '0 : bin_cnt;
    cur_last = (cur_idx == LAST_IDX);
    sum      = s1_re_sq + s1_im_sq;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_cnt      <= '0;
      frame_err_r  <= 1'b0;
      s1_valid     <= 1'b0;
      s1_last      <= 1'b0;
      s1_idx       <= '0;
      s1_re_sq     <= '0;
      s1_im_sq     <= '0;
      s1_min       <= '0;
      max_mag      <= '0;
      max_idx      <= '0;
      s2_min       <= '0;
      s2_done      <= 1'b0;
      out_valid_r  <= 1'b0;
      out_idx_r    <= '0;
      out_mag_r    <= '0;
      out_nopeak_r <= 1'b0;
    end else begin
      frame_err_r <= mid_sof;
      s1_valid    <= bus.in_valid;
      if (bus.in_valid) begin
        bin_cnt  <= cur_last ? '0 : cur_idx + 1'b1;
        s1_idx   <= cur_idx;
        s1_last  <= cur_last;
        s1_re_sq <= re_ext * re_ext;
        s1_im_sq <= im_ext * im_ext;
        if (cur_last) s1_min <= bus.min_mag;
      end

      // Bin 0 loads unconditionally so a stale max from the previous frame never wins.
      s2_done <= s1_valid && s1_last;
      if (s1_valid) begin
        if (s1_idx == '0 || sum > max_mag) begin
          max_mag <= sum;
          max_idx <= s1_idx;
        end
        if (s1_last) s2_min <= s1_min;
      end

      out_valid_r <= s2_done;
      if (s2_done) begin
        out_idx_r    <= max_idx;
        out_mag_r    <= max_mag;
        out_nopeak_r <= (max_mag < s2_min);
      end
    end
  end

  assign bus.out_valid  = out_valid_r;
  assign bus.out_idx    = out_idx_r;
  assign bus.out_mag    = out_mag_r;
  assign bus.out_nopeak = out_nopeak_r;
  assign bus.frame_err  = frame_err_r;
endmodule

// File: tb/tb_spectral_peak_finder.sv
// Bench for spectral_peak_finder: directed frame table, resync/reset sequences
// and randomized frames against a frame-level argmax reference model.
module tb_spectral_peak_finder;
  localparam int DW = 16;
  localparam int NBINS = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spectral_peak_finder_if #(.DW(DW), .IW(IW)) bus ();
  spectral_peak_finder #(.DW(DW), .NBINS(NBINS), .IW(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [IW-1:0] idx;
    logic [31:0]   mag;
    logic          nopeak;
    int            due;
  } res_t;

  typedef struct {
    logic signed [15:0] fill_re, fill_im;
    int                 p1, p2;
    logic signed [15:0] p_re, p_im;
    logic [31:0]        mm;
    logic [IW-1:0]      e_idx;
    logic [31:0]        e_mag;
    logic               e_np;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  res_t    exp_q[$];
  longint  frame_mags[$];
  int      err_due = -1;
  logic [IW-1:0] h_idx = '0;
  logic [31:0]   h_mag = '0;
  logic          h_np = 1'b0;

  logic          got_valid;
  int            got_cyc;
  logic [IW-1:0] got_idx;
  logic [31:0]   got_mag;
  logic          got_np;
  int            nvalid = 0;
  int            err_seen = -1;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, expv);
    end
  endtask

  // One clock: check what the DUT shows now, then drive the next inputs and advance the model.
  task automatic tick(input logic v, input logic sof, input logic signed [15:0] re,
                      input logic signed [15:0] im, input logic [31:0] mm, input logic r);
    logic   exp_valid;
    longint m, best;
    int     bi;
    res_t   res;
    @(negedge clk);
    cyc++;
    exp_valid = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_valid = 1'b1;
      h_idx = exp_q[0].idx;
      h_mag = exp_q[0].mag;
      h_np  = exp_q[0].nopeak;
      void'(exp_q.pop_front());
    end
    chk("out_valid", bus.out_valid, exp_valid);
    chk("out_idx", bus.out_idx, h_idx);
    chk("out_mag", bus.out_mag, h_mag);
    chk("out_nopeak", bus.out_nopeak, h_np);
    chk("frame_err", bus.frame_err, (err_due == cyc) ? 1 : 0);
    if (bus.out_valid === 1'b1) begin
      got_valid = 1'b1;
      got_cyc = cyc;
      got_idx = bus.out_idx;
      got_mag = bus.out_mag;
      got_np = bus.out_nopeak;
      nvalid++;
    end
    if (bus.frame_err === 1'b1) err_seen = cyc;

    rst = r;
    bus.in_valid = v;
    bus.in_sof = sof;
    bus.in_data = {re, im};
    bus.min_mag = mm;

    if (r) begin
      exp_q.delete();
      frame_mags.delete();
      err_due = -1;
      h_idx = '0;
      h_mag = '0;
      h_np = 1'b0;
    end else if (v) begin
      if (sof && frame_mags.size() != 0) begin
        err_due = cyc + 1;
        frame_mags.delete();
      end
      m = longint'(re) * longint'(re) + longint'(im) * longint'(im);
      frame_mags.push_back(m);
      if (frame_mags.size() == NBINS) begin
        best = -1;
        bi = 0;
        foreach (frame_mags[i]) if (frame_mags[i] > best) begin
          best = frame_mags[i];
          bi = i;
        end
        res.idx = IW'(bi);
        res.mag = 32'(best);
        res.nopeak = (best < longint'(mm));
        res.due = cyc + 3;
        exp_q.push_back(res);
        frame_mags.delete();
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'sd0, 16'sd0, 32'd0, 1'b0);
  endtask

  task automatic wait_result(input int last_cyc, input string tag);
    for (int k = 0; k < 8 && !got_valid; k++) idle(1);
    if (!got_valid) chk({tag, "_timeout"}, 0, 1);
    else chk({tag, "_latency"}, got_cyc - last_cyc, 3);
  endtask

  vec_t vecs[7];
  logic signed [15:0] re, im;
  int last_cyc, nv0, sof_cyc;

  initial begin
    vecs[0] = '{16'sd1, 16'sd1, 5, -1, 16'sd300, -16'sd400, 32'd1000, 4'd5, 32'd250000, 1'b0};
    vecs[1] = '{16'sd0, 16'sd0, 3, 9, 16'sd100, 16'sd0, 32'd0, 4'd3, 32'd10000, 1'b0};
    vecs[2] = '{16'sd0, 16'sd0, 12, -1, -16'sd32768, -16'sd32768, 32'd0, 4'd12, 32'h8000_0000, 1'b0};
    vecs[3] = '{16'sd10, 16'sd10, -1, -1, 16'sd0, 16'sd0, 32'd201, 4'd0, 32'd200, 1'b1};
    vecs[4] = '{16'sd10, 16'sd10, -1, -1, 16'sd0, 16'sd0, 32'd200, 4'd0, 32'd200, 1'b0};
    vecs[5] = '{16'sd7, 16'sd0, 15, -1, -16'sd8, 16'sd0, 32'd64, 4'd15, 32'd64, 1'b0};
    vecs[6] = '{16'sd7, 16'sd0, 0, -1, 16'sd0, -16'sd9, 32'd100, 4'd0, 32'd81, 1'b1};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.in_data = '0;
    bus.min_mag = '0;
    repeat (3) @(posedge clk);
    tick(1'b0, 1'b0, 16'sd0, 16'sd0, 32'd0, 1'b1);
    idle(2);

    // Directed frames at full rate
    foreach (vecs[t]) begin
      for (int b = 0; b < NBINS; b++) begin
        if (b == vecs[t].p1 || b == vecs[t].p2) begin re = vecs[t].p_re; im = vecs[t].p_im; end
        else begin re = vecs[t].fill_re; im = vecs[t].fill_im; end
        tick(1'b1, b == 0, re, im, vecs[t].mm, 1'b0);
      end
      last_cyc = cyc;
      got_valid = 1'b0;
      wait_result(last_cyc, $sformatf("vec%0d", t));
      chk($sformatf("vec%0d_idx", t), got_idx, vecs[t].e_idx);
      chk($sformatf("vec%0d_mag", t), got_mag, vecs[t].e_mag);
      chk($sformatf("vec%0d_nopeak", t), got_np, vecs[t].e_np);
    end

    // Resync: sof arrives at bin 7, the partial frame is dropped
    nv0 = nvalid;
    err_seen = -1;
    for (int b = 0; b < 7; b++) tick(1'b1, b == 0, 16'sd900, 16'sd900, 32'd0, 1'b0);
    sof_cyc = cyc + 1;
    for (int b = 0; b < NBINS; b++)
      tick(1'b1, b == 0, (b == 4) ? 16'sd50 : 16'sd1, (b == 4) ? 16'sd50 : 16'sd2, 32'd0, 1'b0);
    last_cyc = cyc;
    got_valid = 1'b0;
    wait_result(last_cyc, "resync");
    chk("resync_err_cycle", err_seen, sof_cyc + 1);
    chk("resync_pulses", nvalid - nv0, 1);
    chk("resync_idx", got_idx, 4);
    chk("resync_mag", got_mag, 5000);

    // Reset mid-frame and directly after a last bin: no result may escape
    for (int b = 0; b < 10; b++) tick(1'b1, b == 0, 16'sd3, 16'sd4, 32'd0, 1'b0);
    tick(1'b0, 1'b0, 16'sd0, 16'sd0, 32'd0, 1'b1);
    idle(1);
    chk("rst_out_idx", bus.out_idx, 0);
    chk("rst_out_mag", bus.out_mag, 0);
    for (int b = 0; b < NBINS; b++) tick(1'b1, b == 0, 16'sd2, 16'sd2, 32'd0, 1'b0);
    nv0 = nvalid;
    tick(1'b0, 1'b0, 16'sd0, 16'sd0, 32'd0, 1'b1);
    idle(6);
    chk("rst_drop_pulses", nvalid - nv0, 0);

    // Randomized back-to-back frames with gaps, stray sofs and occasional resets
    for (int f = 0; f < 1000; f++) begin
      for (int b = 0; b < NBINS; b++) begin
        while ($urandom_range(0, 9) < 2)
          tick(1'b0, 1'($urandom_range(0, 1)), 16'($urandom()), 16'($urandom()), $urandom(), 1'b0);
        if ($urandom_range(0, 299) == 0) tick(1'b0, 1'b0, 16'sd0, 16'sd0, 32'd0, 1'b1);
        case ($urandom_range(0, 3))
          0: begin re = 16'($urandom()); im = 16'($urandom()); end
          1: begin re = 16'($signed(5'($urandom()))); im = 16'($signed(5'($urandom()))); end
          2: begin re = 16'sd5; im = -16'sd5; end
          default: begin
            re = $urandom_range(0, 1) ? -16'sd32768 : 16'sd32767;
            im = $urandom_range(0, 1) ? -16'sd32768 : 16'sd32767;
          end
        endcase
        tick(1'b1,
             (b == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 99) == 0),
             re, im,
             $urandom_range(0, 3) == 0 ? $urandom() : 32'($urandom_range(0, 300000)),
             1'b0);
      end
    end
    idle(6);
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
